spi_line_fetcher: RTL

SPI_LINE_FETCHER -- requirements
Module: spi_line_fetcher

---
 rtl/spi_line_fetcher.sv | 107 ++++++++++
 1 files changed

// File: rtl/spi_line_fetcher.sv
// spi_line_fetcher: reads one BUFFER_DEPTH-bit line from SPI flash into a ping-pong bit buffer
`timescale 1ns/1ps
module spi_line_fetcher #(
  parameter int BUFFER_DEPTH = 192,
  parameter int ADDR_BITS = 24,
  parameter int FAST_READ = 0,
  parameter int CS_GAP = 2,
  localparam int IW = $clog2(BUFFER_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 busy,
  output logic                 done,
  input  logic [IW-1:0]        rd_index,
  output logic                 rd_data,
  output logic                 spi_cs,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);
  localparam int M0 = ADDR_BITS > BUFFER_DEPTH ? ADDR_BITS : BUFFER_DEPTH;
  localparam int M1 = M0 > CS_GAP ? M0 : CS_GAP;
  localparam int CW = $clog2(M1 > 8 ? M1 : 8);
  localparam int SW = 8 + ADDR_BITS;
  localparam logic [7:0] RD_CMD = FAST_READ != 0 ? 8'h0B : 8'h03;
  localparam logic [CW-1:0] L_BYTE = CW'(7);
  localparam logic [CW-1:0] L_ADDR = CW'(ADDR_BITS - 1);
  localparam logic [CW-1:0] L_DATA = CW'(BUFFER_DEPTH - 1);
  localparam logic [CW-1:0] L_GAP = CW'(CS_GAP - 1);
  localparam logic [IW:0] BD_W = (IW+1)'(BUFFER_DEPTH);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, GAP} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] sh;
  logic last, front_sel;
  logic [BUFFER_DEPTH-1:0] bank0, bank1, front;
  logic [IW-1:0] di;

  // Phase-end detection, next phase selection and per-phase cycle counting
  always_comb begin
    last = state == CMD   ? cnt == L_BYTE :
           state == ADDR  ? cnt == L_ADDR :
           state == DUMMY ? cnt == L_BYTE :
           state == DATA  ? cnt == L_DATA :
           state == GAP   ? cnt == L_GAP  : 1'b0;
    state_n = state;
    if (state == IDLE && start)
      state_n = CMD;
    else if (last)
      state_n = state == CMD   ? ADDR :
                state == ADDR  ? (FAST_READ != 0 ? DUMMY : DATA) :
                state == DUMMY ? DATA :
                state == DATA  ? GAP : IDLE;
    cnt_n = (state == IDLE || last) ? '0 : cnt + 1'b1;
  end

  // FSM state and phase counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end

  // Command+address shifter: loaded on accept, MSB shifted out through CMD and ADDR
  always_ff @(posedge clk or posedge reset)
    if (reset)
      sh <= '0;
    else if (state == IDLE && start)
      sh <= {RD_CMD, addr};
    else if (state == CMD || state == ADDR)
      sh <= sh << 1;

  // Front/back swap on the edge that closes the last data bit
  always_ff @(posedge clk or posedge reset)
    if (reset)
      front_sel <= 1'b0;
    else if (state == DATA && last)
      front_sel <= ~front_sel;

  // MISO capture into the back bank on the falling system clock (rising SPI clock)
  always_ff @(negedge clk or posedge reset)
    if (reset) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (state == DATA) begin
      if (front_sel)
        bank0[di] <= spi_miso;
      else
        bank1[di] <= spi_miso;
    end

  assign di = cnt[IW-1:0];
  assign front = front_sel ? bank1 : bank0;
  assign busy = state != IDLE;
  assign done = state == GAP && cnt == '0;
  assign spi_cs = state == CMD || state == ADDR || state == DUMMY || state == DATA;
  assign spi_mosi = (state == CMD || state == ADDR) && sh[SW-1];
  assign spi_sclk = ~clk;
  assign rd_data = {1'b0, rd_index} < BD_W && front[rd_index];
endmodule
